dac_scan_sequencer: RTL and testbench
=====================================

Name: dac_scan_sequencer

Overview:
Sequences an MCP4921 SPI-DAC master through a voltage scan. Each scan steps the 12-bit code from a start value to a stop value by a fixed step. For every point the block issues a load to the DAC master, waits for the master's nLDAC latch pulse, dwells a programmed number of cycles, then strobes the downstream acquisition logic. It replaces ad-hoc load/start_step pulsing from the register file with a single programmable scan engine.

Parameters:
CODE_WIDTH, 12, DAC code width
DWELL_WIDTH, 16, width of dwell counter
LOAD_CYCLES, 10, cycles dac_load is held high (master runs on slower PLL clock)
TIMEOUT_CYCLES, 4096, max cycles from LOAD entry to completed nLDAC pulse
CFG_BITS, 4'b0011, MCP4921 header {A/B, BUF, GA, SHDN} prepended to code

Ports:
clk  in  1  system clock
nres  in  1  asynchronous active-low reset
start_scan  in  1  one-cycle scan request; honoured only in IDLE
abort  in  1  one-cycle abort; honoured in any state
code_start  in  CODE_WIDTH  first code
code_stop  in  CODE_WIDTH  last code
code_step  in  CODE_WIDTH  step magnitude
dwell  in  DWELL_WIDTH  settle cycles per point after latch
dac_nldac  in  1  nLDAC from DAC master (asynchronous to clk)
dac_data  out  16  {CFG_BITS, cur_code} to DAC master
dac_load  out  1  load request to DAC master
step_strobe  out  1  one-cycle pulse per settled point
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal scan completion
err  out  1  sticky timeout flag, cleared by next accepted start_scan
cur_code  out  CODE_WIDTH  code currently driven

Behaviour:
- Reset (nres low, async): state IDLE. dac_load, step_strobe, busy, done, err, cur_code = 0. dac_data = {CFG_BITS, 0}. Sync flops = 1.
- dac_nldac passes through a 2-flop synchronizer; nldac_s denotes its output. Edge detection uses nldac_s and a delayed copy.
- On start_scan accepted: latch start/stop/step/dwell. cur_code <= code_start. dir = up if code_stop >= code_start, else down. Clear err.
- States:
  - IDLE: start_scan and not abort -> LOAD on next edge.
  - LOAD: dac_load = 1 for exactly LOAD_CYCLES cycles, starting the cycle after acceptance -> WAIT_LO.
  - WAIT_LO: wait for a falling edge of nldac_s -> WAIT_HI.
  - WAIT_HI: wait for a rising edge of nldac_s -> DWELL; load dwell counter.
  - DWELL: count down dwell cycles; dwell = 0 means one cycle -> STROBE.
  - STROBE: step_strobe = 1 for one cycle -> NEXT.
  - NEXT: one cycle; compute the next code, or finish.
- Timeout counter starts at LOAD entry and runs through LOAD, WAIT_LO and WAIT_HI. On reaching TIMEOUT_CYCLES: err = 1, go to IDLE, no done pulse, no strobe.
- NEXT arithmetic uses CODE_WIDTH+1 bits, so there is no wrap-around.
  - If cur_code == code_stop, or code_step == 0: done pulse, go to IDLE.
  - Up: nxt = cur + step. Down: nxt = cur - step.
  - If nxt passes code_stop (greater when up, less when down, or borrow when down): nxt = code_stop. The last point is therefore always exactly code_stop.
  - cur_code <= nxt, go to LOAD.
- dac_data is registered from cur_code and is stable from LOAD entry through NEXT.
- abort: on the next edge go to IDLE. dac_load and step_strobe drop in that same edge. No done pulse. err is unchanged. cur_code is held.
- abort and start_scan together in IDLE: abort wins, scan not started.
- start_scan while busy: ignored. Latched config is unaffected by input changes mid-scan.
- Points per scan = ceil(|stop-start|/step) + 1 (1 if step = 0). One LOAD and one step_strobe per point.

Test Plan:
- Bench DAC model drives nLDAC low 4 cycles, starting 20 cycles after dac_load rises. Ascending scan start=0, stop=100, step=50, dwell=3 -> dac_data 0x3000, 0x3032, 0x3064. Three step_strobes, each ≥4 cycles after the nLDAC rise. done pulses once; busy falls the same cycle done pulses.
- Clamp and descending: 0→100 step 40 -> codes 0, 40, 80, 100. Then 100→0 step 60 -> codes 100, 40, 0. No wrap to 0xFxx.
- Degenerate: step=0, start=stop=0xFFF, dwell=0 -> single load of 0x3FFF, one strobe, done; dac_load high exactly 10 cycles.
- Timeout: DAC model holds nLDAC high -> err = 1 exactly TIMEOUT_CYCLES after LOAD entry, busy drops, no done. Next start_scan clears err.
- Abort mid-DWELL of point 2 -> IDLE next edge, no strobe, no done, cur_code holds the point-2 code. Same-cycle start+abort in IDLE -> busy stays 0.
- Async reset asserted during LOAD -> dac_load and busy drop immediately without a clock edge. After release, start_scan runs a full scan normally.

Source files
------------

// File: rtl/dac_scan_sequencer.sv
// dac_scan_sequencer: programmable voltage-scan engine for an MCP4921 SPI-DAC
// master. Each point is loaded into the DAC, latched by the master's nLDAC
// pulse, allowed to settle for a programmed dwell, then announced downstream
// with a one-cycle strobe. The last point of a scan is always exactly the
// programmed stop code.
module dac_scan_sequencer #(
    parameter int         CODE_WIDTH     = 12,
    parameter int         DWELL_WIDTH    = 16,
    parameter int         LOAD_CYCLES    = 10,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [3:0] CFG_BITS       = 4'b0011
) (
    input  logic                    clk,
    input  logic                    nres,
    input  logic                    start_scan,
    input  logic                    abort,
    input  logic [CODE_WIDTH-1:0]   code_start,
    input  logic [CODE_WIDTH-1:0]   code_stop,
    input  logic [CODE_WIDTH-1:0]   code_step,
    input  logic [DWELL_WIDTH-1:0]  dwell,
    input  logic                    dac_nldac,
    output logic [CODE_WIDTH+3:0]   dac_data,
    output logic                    dac_load,
    output logic                    step_strobe,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CODE_WIDTH-1:0]   cur_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DWELL,
        S_STROBE,
        S_NEXT
    } state_t;

    // The timeout counter also times the LOAD phase, so it must hold TIMEOUT_CYCLES.
    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   LOAD_LAST    = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     nldac_meta;
    logic                     nldac_s;
    logic                     nldac_d;
    logic                     nldac_fall;
    logic                     nldac_rise;
    logic [TW-1:0]            tcnt;
    logic [DWELL_WIDTH-1:0]   dcnt;
    logic [CODE_WIDTH-1:0]    scan_stop;
    logic [CODE_WIDTH-1:0]    scan_step;
    logic [DWELL_WIDTH-1:0]   scan_dwell;
    logic                     dir_up;
    logic                     accept;
    logic                     timed;
    logic                     timeout_hit;
    logic                     finish;
    logic [CODE_WIDTH-1:0]    nxt_code;

    // Next scan point, computed one bit wider so neither direction can wrap;
    // any overshoot past the stop code is clamped onto it.
    function automatic logic [CODE_WIDTH-1:0] next_point(
        input logic [CODE_WIDTH-1:0] cur,
        input logic [CODE_WIDTH-1:0] step,
        input logic [CODE_WIDTH-1:0] stop,
        input logic                  up
    );
        logic [CODE_WIDTH:0]   sum_ext;
        logic [CODE_WIDTH:0]   diff_ext;
        logic [CODE_WIDTH-1:0] res;
        sum_ext  = {1'b0, cur} + {1'b0, step};
        diff_ext = {1'b0, cur} - {1'b0, step};
        res      = stop;
        if (up) begin
            if (sum_ext <= {1'b0, stop})
                res = sum_ext[CODE_WIDTH-1:0];
        end else begin
            if (!diff_ext[CODE_WIDTH] && (diff_ext[CODE_WIDTH-1:0] >= stop))
                res = diff_ext[CODE_WIDTH-1:0];
        end
        return res;
    endfunction

    assign accept      = (state == S_IDLE) && start_scan && !abort;
    assign timed       = (state == S_LOAD) || (state == S_WAIT_LO) || (state == S_WAIT_HI);
    assign timeout_hit = (tcnt == TIMEOUT_LAST);
    assign finish      = (cur_code == scan_stop) || (scan_step == '0);
    assign nxt_code    = next_point(cur_code, scan_step, scan_stop, dir_up);
    assign nldac_fall  = nldac_d && !nldac_s;
    assign nldac_rise  = !nldac_d && nldac_s;

    // Bring the master's nLDAC into this clock domain and keep a delayed copy for edge detection.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            nldac_meta <= 1'b1;
            nldac_s    <= 1'b1;
            nldac_d    <= 1'b1;
        end else begin
            nldac_meta <= dac_nldac;
            nldac_s    <= nldac_meta;
            nldac_d    <= nldac_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; abort overrides every state, a finished latch wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_scan) state_nxt = S_LOAD;
                S_LOAD: begin
                    if (tcnt == LOAD_LAST)   state_nxt = S_WAIT_LO;
                    else if (timeout_hit)    state_nxt = S_IDLE;
                end
                S_WAIT_LO: begin
                    if (nldac_fall)          state_nxt = S_WAIT_HI;
                    else if (timeout_hit)    state_nxt = S_IDLE;
                end
                S_WAIT_HI: begin
                    if (nldac_rise)          state_nxt = S_DWELL;
                    else if (timeout_hit)    state_nxt = S_IDLE;
                end
                S_DWELL:   if (dcnt == '0) state_nxt = S_STROBE;
                S_STROBE:  state_nxt = S_NEXT;
                S_NEXT:    state_nxt = finish ? S_IDLE : S_LOAD;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs registered from the next state so they are glitch-free toward the slower DAC clock domain.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            dac_load    <= 1'b0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dac_load    <= (state_nxt == S_LOAD);
            step_strobe <= (state_nxt == S_STROBE);
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // Timeout/load counter runs from LOAD entry until the latch completes, and doubles as the LOAD length timer.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres)
            tcnt <= '0;
        else if (timed)
            tcnt <= tcnt + TW'(1);
        else
            tcnt <= '0;
    end

    // Dwell countdown, armed on the nLDAC rising edge; a dwell of zero still costs one cycle.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres)
            dcnt <= '0;
        else if ((state == S_WAIT_HI) && nldac_rise)
            dcnt <= scan_dwell;
        else if ((state == S_DWELL) && (dcnt != '0))
            dcnt <= dcnt - DWELL_WIDTH'(1);
    end

    // Scan configuration captured at acceptance so mid-scan input changes have no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            scan_stop  <= code_stop;
            scan_step  <= code_step;
            scan_dwell <= dwell;
            dir_up     <= (code_stop >= code_start);
        end
    end

    // Current code and DAC word move together so dac_data is valid from the first LOAD cycle.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            cur_code <= '0;
            dac_data <= {CFG_BITS, {CODE_WIDTH{1'b0}}};
        end else if (accept) begin
            cur_code <= code_start;
            dac_data <= {CFG_BITS, code_start};
        end else if ((state == S_NEXT) && !abort && !finish) begin
            cur_code <= nxt_code;
            dac_data <= {CFG_BITS, nxt_code};
        end
    end

    // Completion pulse and sticky timeout flag; only a timeout (not an abort) leaves a timed state for IDLE with err.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == S_NEXT) && !abort && finish;
            if (accept)
                err <= 1'b0;
            else if (timed && !abort && (state_nxt == S_IDLE))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Testbench for dac_scan_sequencer: a DAC-master model answers each load with
// an nLDAC pulse, a scan-level model predicts the code sequence, and a monitor
// checks every load, strobe and completion against it.
module tb_dac_scan_sequencer;

    localparam int LOADC     = 10;
    localparam int TMO       = 4096;
    localparam int LOW_START = 20;
    localparam int LOW_LEN   = 4;

    logic        clk = 1'b0;
    logic        nres;
    logic        start_scan;
    logic        abort;
    logic [11:0] code_start;
    logic [11:0] code_stop;
    logic [11:0] code_step;
    logic [15:0] dwell;
    logic        dac_nldac;
    logic [15:0] dac_data;
    logic        dac_load;
    logic        step_strobe;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] cur_code;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] exp_q[$];
    logic [15:0] got_q[$];
    int          load_idx, strobe_idx, done_cnt, load_len, last_load_len;
    int          cyc = 0;
    int          load_rise_cyc, err_rise_cyc, nldac_rise_cyc, dwell_cur;
    int          dac_cnt = -1;
    bit          mon_en = 1'b0;
    bit          hold_high = 1'b0;
    logic        load_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic        err_prev = 1'b0;
    logic        dac_load_seen = 1'b0;

    always #5 clk = ~clk;

    dac_scan_sequencer #(
        .CODE_WIDTH     (12),
        .DWELL_WIDTH    (16),
        .LOAD_CYCLES    (LOADC),
        .TIMEOUT_CYCLES (TMO),
        .CFG_BITS       (4'b0011)
    ) dut (
        .clk         (clk),
        .nres        (nres),
        .start_scan  (start_scan),
        .abort       (abort),
        .code_start  (code_start),
        .code_stop   (code_stop),
        .code_step   (code_step),
        .dwell       (dwell),
        .dac_nldac   (dac_nldac),
        .dac_data    (dac_data),
        .dac_load    (dac_load),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cur_code    (cur_code)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Scan-level model: points are start, start+-k*step, ..., and finally stop.
    task automatic build_exp(input int s, input int e, input int st);
        int span, dir, pts;
        exp_q.delete();
        if (st == 0) begin
            exp_q.push_back(12'(s));
        end else begin
            span = (e >= s) ? (e - s) : (s - e);
            dir  = (e >= s) ? 1 : -1;
            pts  = (span + st - 1) / st + 1;
            for (int i = 0; i < pts - 1; i++)
                exp_q.push_back(12'(s + dir * i * st));
            exp_q.push_back(12'(e));
        end
    endtask

    task automatic monitor_step();
        cyc++;
        if (mon_en) begin
            if (dac_load && !load_prev) begin
                if (load_idx < exp_q.size())
                    chk("load_dac_data", 32'(dac_data), 32'({4'h3, exp_q[load_idx]}));
                else
                    chk("extra_load", 32'(load_idx), 32'(exp_q.size() - 1));
                got_q.push_back(dac_data);
                load_idx++;
                load_len = 1;
                if (load_rise_cyc < 0) load_rise_cyc = cyc;
            end else if (dac_load) begin
                load_len++;
            end
            if (!dac_load && load_prev) begin
                chk("load_length", 32'(load_len), 32'(LOADC));
                last_load_len = load_len;
            end
            if (step_strobe) begin
                if (strobe_idx < exp_q.size())
                    chk("strobe_code", 32'(cur_code), 32'(exp_q[strobe_idx]));
                else
                    chk("extra_strobe", 32'(strobe_idx), 32'(exp_q.size() - 1));
                chk("strobe_after_settle", 32'((cyc - nldac_rise_cyc) >= dwell_cur + 1), 32'(1));
                strobe_idx++;
            end
            if (done) begin
                chk("done_busy_low", 32'(busy), 32'(0));
                chk("done_busy_was_high", 32'(busy_prev), 32'(1));
                done_cnt++;
            end
            if (busy)
                chk("dac_data_tracks_code", 32'(dac_data), 32'({4'h3, cur_code}));
            if (err && !err_prev) err_rise_cyc = cyc;
        end
        load_prev = dac_load;
        busy_prev = busy;
        err_prev  = err;
    endtask

    // DAC master model: nLDAC low for LOW_LEN cycles, LOW_START cycles after dac_load rises.
    task automatic dac_step();
        logic nv;
        if (dac_load && !dac_load_seen && !hold_high) dac_cnt = 0;
        else if (dac_cnt >= 0) dac_cnt++;
        dac_load_seen = dac_load;
        if (dac_cnt >= LOW_START + LOW_LEN) dac_cnt = -1;
        nv = !(dac_cnt >= LOW_START && dac_cnt < LOW_START + LOW_LEN);
        if (nv && !dac_nldac) nldac_rise_cyc = cyc;
        dac_nldac = nv;
    endtask

    task automatic start_task(input int s, input int e, input int st, input int dw);
        @(negedge clk);
        build_exp(s, e, st);
        got_q.delete();
        load_idx = 0; strobe_idx = 0; done_cnt = 0;
        load_rise_cyc = -1; err_rise_cyc = -1;
        dwell_cur  = dw;
        code_start = 12'(s); code_stop = 12'(e); code_step = 12'(st); dwell = 16'(dw);
        start_scan = 1'b1;
        @(negedge clk);
        start_scan = 1'b0;
        code_start = 12'hABC; code_stop = 12'h123; code_step = 12'h001; dwell = 16'd9;
        chk("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'(0));
    endtask

    task automatic check_got(input string name, input int n,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_points"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < got_q.size())
                chk({name, "_word"}, 32'(got_q[i]), 32'(e[i]));
        chk({name, "_strobes"}, 32'(strobe_idx), 32'(n));
        chk({name, "_done_once"}, 32'(done_cnt), 32'(1));
        chk({name, "_err_clear"}, 32'(err), 32'(0));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int snap, n;
        nres = 1'b0; start_scan = 1'b0; abort = 1'b0;
        code_start = '0; code_stop = '0; code_step = '0; dwell = '0;
        dac_nldac = 1'b1;
        load_idx = 0; strobe_idx = 0; done_cnt = 0; load_len = 0; last_load_len = 0;
        load_rise_cyc = -1; err_rise_cyc = -1; nldac_rise_cyc = 0; dwell_cur = 0;
        fork
            forever begin @(posedge clk); #1; monitor_step(); end
            forever begin @(negedge clk); dac_step(); end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_dac_load", 32'(dac_load), 32'(0));
        chk("rst_step_strobe", 32'(step_strobe), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_cur_code", 32'(cur_code), 32'(0));
        chk("rst_dac_data", 32'(dac_data), 32'(16'h3000));
        nres = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        start_task(0, 100, 50, 3);
        wait_idle("asc_idle", 1000);
        check_got("asc", 3, 16'h3000, 16'h3032, 16'h3064, 16'h0000);

        start_task(0, 100, 40, 1);
        wait_idle("clamp_idle", 1000);
        check_got("clamp", 4, 16'h3000, 16'h3028, 16'h3050, 16'h3064);

        start_task(100, 0, 60, 2);
        wait_idle("desc_idle", 1000);
        check_got("desc", 3, 16'h3064, 16'h3028, 16'h3000, 16'h0000);

        start_task(12'hFFF, 12'hFFF, 0, 0);
        wait_idle("degen_idle", 1000);
        check_got("degen", 1, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000);
        chk("degen_load_len", 32'(last_load_len), 32'(10));

        hold_high = 1'b1;
        start_task(0, 100, 50, 3);
        wait_idle("timeout_idle", TMO + 500);
        chk("timeout_err", 32'(err), 32'(1));
        chk("timeout_latency", 32'(err_rise_cyc - load_rise_cyc), 32'(TMO));
        chk("timeout_no_done", 32'(done_cnt), 32'(0));
        chk("timeout_no_strobe", 32'(strobe_idx), 32'(0));
        hold_high = 1'b0;
        start_task(0, 100, 50, 3);
        chk("err_cleared_by_start", 32'(err), 32'(0));
        wait_idle("post_timeout_idle", 1000);
        check_got("post_timeout", 3, 16'h3000, 16'h3032, 16'h3064, 16'h0000);

        start_task(0, 100, 50, 200);
        n = 0;
        while (load_idx < 2 && n < 1000) begin @(negedge clk); n++; end
        chk("abort_reached_pt2", 32'(load_idx), 32'(2));
        n = 0;
        while (dac_load && n < 50) begin @(negedge clk); n++; end
        repeat (60) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_load", 32'(dac_load), 32'(0));
        chk("abort_code_held", 32'(cur_code), 32'(50));
        repeat (250) @(negedge clk);
        chk("abort_no_strobe", 32'(strobe_idx), 32'(1));
        chk("abort_no_done", 32'(done_cnt), 32'(0));
        chk("abort_code_still", 32'(cur_code), 32'(50));
        chk("abort_err_kept", 32'(err), 32'(0));

        snap = load_idx;
        @(negedge clk);
        start_scan = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_scan = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);
        chk("start_abort_busy_later", 32'(busy), 32'(0));
        chk("start_abort_no_load", 32'(load_idx), 32'(snap));

        start_task(0, 100, 50, 3);
        chk("rst_mid_load_loading", 32'(dac_load), 32'(1));
        #2;
        mon_en = 1'b0;
        nres = 1'b0;
        #1;
        chk("async_rst_load", 32'(dac_load), 32'(0));
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_code", 32'(cur_code), 32'(0));
        @(negedge clk);
        nres = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        start_task(0, 100, 50, 3);
        wait_idle("post_reset_idle", 1000);
        check_got("post_reset", 3, 16'h3000, 16'h3032, 16'h3064, 16'h0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
